cycle_countdown: RTL and testbench

//  Loadable down-counter with a start/done handshake for multdiv sequencing.

---
 rtl/cycle_countdown_pkg.sv | 12 +
 rtl/cycle_countdown_tff_down_counter.sv | 46 ++++
 rtl/cycle_countdown.sv | 69 ++++++
 tb/tb_cycle_countdown.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cycle_countdown_pkg.sv
// Shared state encoding and default width for the multdiv iteration down-counter.
package cycle_countdown_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cycle_countdown_tff_down_counter.sv
// Loadable down-counter built as a toggle register: bit i flips when every
// lower bit is zero (borrow chain). Load takes priority over decrement.
module tff_down_counter
  import cycle_countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tog;
  logic [WIDTH:0]   zlow;
  logic             dec_ok;

  // zlow[i]: bits [i-1:0] are all zero; zlow[WIDTH] flags a zero count,
  // which blocks the decrement so the count never wraps.
  always_comb begin
    zlow[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) zlow[i+1] = zlow[i] & ~cnt_q[i];
  end

  assign dec_ok = dec & ~zlow[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_tog
    assign tog[i] = dec_ok & zlow[i];
  end

  always_comb begin
    cnt_d = cnt_q ^ tog;
    if (load) cnt_d = d;
  end

  always_ff @(posedge clock) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Q = cnt_q;

endmodule

// File: rtl/cycle_countdown.sv
// Iteration budget counter: start loads a count, en decrements it in RUN,
// and done pulses for one cycle when it reaches zero.
module cycle_countdown
  import cycle_countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             ready,
  output logic             done
);

  state_t           state_q, state_d;
  logic             load, dec;
  logic [WIDTH-1:0] cnt;

  tff_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock (clock),
    .clr   (clr),
    .load  (load),
    .dec   (dec),
    .d     (load_val),
    .Q     (cnt)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      // DONE accepts a new start just like IDLE, so runs can chain without a bubble.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (load_val == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (en) begin
          dec = 1'b1;
          if (cnt == WIDTH'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign Q     = cnt;
  assign busy  = (state_q == ST_RUN);
  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_cycle_countdown.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_cycle_countdown;

  localparam int W = 6;

  logic         clock = 1'b0;
  logic         clr = 1'b0, start = 1'b0, en = 1'b0, abort = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] Q;
  logic         busy, ready, done;

  typedef struct {
    logic [W-1:0] q;
    logic         b, r, d;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cycle_countdown #(.WIDTH(W)) dut (
    .clock    (clock),
    .clr      (clr),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .Q        (Q),
    .busy     (busy),
    .ready    (ready),
    .done     (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({Q, busy, ready, done} !== {e.q, e.b, e.r, e.d}) begin
        bad++;
        $display("FAIL %s: got Q=%0d busy=%b ready=%b done=%b, want Q=%0d busy=%b ready=%b done=%b",
                 e.nm, Q, busy, ready, done, e.q, e.b, e.r, e.d);
      end
    end
  end

  task automatic cyc(input string nm, input logic c, s, input logic [W-1:0] lv,
                     input logic e, a, input logic [W-1:0] eq, input logic eb, er, ed);
    exp_t x;
    clr = c; start = s; load_val = lv; en = e; abort = a;
    @(posedge clock);
    x.q = eq; x.b = eb; x.r = er; x.d = ed; x.nm = nm;
    sb.push_back(x);
    #1;
  endtask

  // Reference model for the random phase.
  int unsigned m_st = 0; // 0 idle, 1 run, 2 done
  int unsigned m_q  = 0;

  task automatic model_step(input logic c, s, input logic [W-1:0] lv, input logic e, a);
    if (c) begin
      m_st = 0; m_q = 0;
    end else if (m_st == 1) begin
      if (a) m_st = 0;
      else if (e) begin
        if (m_q == 1) begin m_q = 0; m_st = 2; end
        else m_q = m_q - 1;
      end
    end else if (s) begin
      m_q  = lv;
      m_st = (lv == 0) ? 2 : 1;
    end else begin
      m_st = 0;
    end
  endtask

  initial begin
    // 1: reset overrides a held start
    cyc("rst0", 1, 1, 6'd5, 1, 0, 0, 0, 1, 0);
    cyc("rst1", 1, 1, 6'd5, 1, 0, 0, 0, 1, 0);

    // 2: load 3, count down
    cyc("n3_ld", 0, 1, 6'd3, 1, 0, 3, 1, 0, 0);
    cyc("n3_2",  0, 0, 6'd0, 1, 0, 2, 1, 0, 0);
    cyc("n3_1",  0, 0, 6'd0, 1, 0, 1, 1, 0, 0);
    cyc("n3_dn", 0, 0, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("n3_id", 0, 0, 6'd0, 1, 0, 0, 0, 1, 0);

    // 3: zero load goes straight to DONE; full-scale load
    cyc("n0_dn", 0, 1, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("n0_id", 0, 0, 6'd0, 1, 0, 0, 0, 1, 0);
    cyc("n63_ld", 0, 1, 6'd63, 1, 0, 63, 1, 0, 0);
    for (int k = 1; k <= 62; k++) cyc("n63_run", 0, 0, 6'd0, 1, 0, 6'(63 - k), 1, 0, 0);
    cyc("n63_dn", 0, 0, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("n63_id", 0, 0, 6'd0, 1, 0, 0, 0, 1, 0);
    cyc("n63_nowrap", 0, 0, 6'd0, 1, 0, 0, 0, 1, 0);

    // 4: stalls hold the count
    cyc("st_ld", 0, 1, 6'd5, 1, 0, 5, 1, 0, 0);
    cyc("st_4",  0, 0, 6'd0, 1, 0, 4, 1, 0, 0);
    cyc("st_h4", 0, 0, 6'd0, 0, 0, 4, 1, 0, 0);
    cyc("st_3",  0, 0, 6'd0, 1, 0, 3, 1, 0, 0);
    cyc("st_h3", 0, 0, 6'd0, 0, 0, 3, 1, 0, 0);
    cyc("st_2",  0, 0, 6'd0, 1, 0, 2, 1, 0, 0);
    cyc("st_1",  0, 0, 6'd0, 1, 0, 1, 1, 0, 0);
    cyc("st_dn", 0, 0, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("st_id", 0, 0, 6'd0, 0, 0, 0, 0, 1, 0);

    // 5: abort, start ignored in RUN, back-to-back from DONE
    cyc("ab_ld",   0, 1, 6'd4, 1, 0, 4, 1, 0, 0);
    cyc("ab_3",    0, 0, 6'd0, 1, 0, 3, 1, 0, 0);
    cyc("ab_2",    0, 0, 6'd0, 1, 0, 2, 1, 0, 0);
    cyc("ab_hit",  0, 0, 6'd0, 1, 1, 2, 0, 1, 0);
    cyc("ab_hold", 0, 0, 6'd0, 0, 0, 2, 0, 1, 0);
    cyc("ig_ld",   0, 1, 6'd3, 1, 0, 3, 1, 0, 0);
    cyc("ig_st",   0, 1, 6'd9, 1, 0, 2, 1, 0, 0);
    cyc("ig_1",    0, 0, 6'd0, 1, 0, 1, 1, 0, 0);
    cyc("ig_dn",   0, 0, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("b2b_ld",  0, 1, 6'd4, 1, 0, 4, 1, 0, 0);
    cyc("b2b_ab",  0, 0, 6'd0, 1, 1, 4, 0, 1, 0);
    cyc("abst_id", 0, 1, 6'd2, 1, 1, 2, 1, 0, 0);
    cyc("abst_1",  0, 0, 6'd0, 1, 0, 1, 1, 0, 0);
    cyc("abst_dn", 0, 0, 6'd0, 1, 0, 0, 0, 1, 1);
    cyc("abdn_ig", 0, 0, 6'd0, 1, 1, 0, 0, 1, 0);

    // 6: clr mid-run drops the count with no done
    cyc("cl_ld",  0, 1, 6'd5, 1, 0, 5, 1, 0, 0);
    cyc("cl_4",   0, 0, 6'd0, 1, 0, 4, 1, 0, 0);
    cyc("cl_3",   0, 0, 6'd0, 1, 0, 3, 1, 0, 0);
    cyc("cl_hit", 1, 0, 6'd0, 1, 0, 0, 0, 1, 0);
    cyc("cl_id",  0, 0, 6'd0, 1, 0, 0, 0, 1, 0);

    // random phase against the model, starting from the idle Q=0 state above
    m_st = 0; m_q = 0;
    for (int i = 0; i < 300; i++) begin
      logic c, s, e, a;
      logic [W-1:0] lv;
      c  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 2) == 0);
      e  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 11) == 0);
      lv = 6'($urandom_range(0, 7));
      model_step(c, s, lv, e, a);
      cyc("rand", c, s, lv, e, a, 6'(m_q), m_st == 1, m_st != 1, m_st == 2);
    end

    cyc("tail", 1, 0, 6'd0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
